// File: rtl/voice_allocator_pkg.sv
// Shared types and constants for the voice allocator.
//   key_t          : note key number carried on events and driven to oscillators
//   KEY_SILENT     : key value that means "no note"; note-ons with it are dropped
//   NUM_VOICES_DEF : default size of the voice pool
//   AGE_WIDTH_DEF  : default width of the per-voice age counter
//   alloc_state_e  : allocator FSM state encoding
package voice_allocator_pkg;

   localparam int KEY_WIDTH     = 7;
   localparam int NUM_VOICES_DEF = 4;
   localparam int AGE_WIDTH_DEF  = 4;

   typedef logic [KEY_WIDTH-1:0] key_t;

   localparam key_t KEY_SILENT = '0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_COMMIT = 2'd2
   } alloc_state_e;

endpackage

// File: rtl/voice_allocator_slot.sv
// One voice of the pool: key, gate and age registers.
//   clk, rst  : clock, synchronous active-high reset
//   load      : take key_in, open gate, clear age (new note or steal)
//   retrig    : clear age only (same key pressed again)
//   rel       : close gate, keep key so the oscillator runs through release
//   age_inc   : one step older, saturating; only applies while gated
//   key_in    : key to load
//   key, gate, age : current register contents
module voice_slot
   import voice_allocator_pkg::*;
#(
   parameter int AGE_WIDTH = AGE_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 retrig,
   input  logic                 rel,
   input  logic                 age_inc,
   input  key_t                 key_in,
   output key_t                 key,
   output logic                 gate,
   output logic [AGE_WIDTH-1:0] age
);

   localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

   always_ff @(posedge clk) begin
      if (rst) begin
         key  <= KEY_SILENT;
         gate <= 1'b0;
         age  <= '0;
      end else if (load) begin
         key  <= key_in;
         gate <= 1'b1;
         age  <= '0;
      end else if (retrig) begin
         age  <= '0;
      end else if (rel) begin
         gate <= 1'b0;
      end else if (age_inc && gate && (age != AGE_MAX)) begin
         age  <= age + 1'b1;
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator. Accepts note-on/off events over valid/ready,
// scans the voice pool one slot per cycle, then commits one update.
//   clk, rst   : clock, synchronous active-high reset
//   note_valid : event present
//   note_on    : 1 = note-on, 0 = note-off
//   note_key   : key of the event
//   note_ready : allocator idle and able to accept an event
//   voice_key  : packed per-voice key, slice i feeds oscillator i
//   voice_gate : per-voice held flag
//   steal      : one-cycle pulse when a held voice was reassigned
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for an event, note_ready high
// ST_SCAN   | examining voice[scan_idx], one voice per cycle
// ST_COMMIT | apply retrigger / assign / steal / release, then back idle
module voice_allocator
   import voice_allocator_pkg::*;
#(
   parameter int NUM_VOICES = NUM_VOICES_DEF,
   parameter int AGE_WIDTH  = AGE_WIDTH_DEF
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            note_valid,
   input  logic                            note_on,
   input  key_t                            note_key,
   output logic                            note_ready,
   output logic [NUM_VOICES*KEY_WIDTH-1:0] voice_key,
   output logic [NUM_VOICES-1:0]           voice_gate,
   output logic                            steal
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VOICES - 1);

   alloc_state_e state_q, state_d;

   logic                 ev_on_q;
   key_t                 ev_key_q;
   logic [IDX_W-1:0]     scan_idx_q;

   logic                 match_found_q, free_found_q, old_found_q;
   logic [IDX_W-1:0]     match_idx_q, free_idx_q, old_idx_q;
   logic [AGE_WIDTH-1:0] old_age_q;

   key_t                 slot_key [NUM_VOICES];
   logic [NUM_VOICES-1:0] slot_gate;
   logic [AGE_WIDTH-1:0] slot_age [NUM_VOICES];

   logic [NUM_VOICES-1:0] load, retrig, rel, age_inc, sel;
   logic                  steal_d;

   logic accept;
   logic silent;

   key_t                 cur_key;
   logic                 cur_gate;
   logic [AGE_WIDTH-1:0] cur_age;

   assign note_ready = (state_q == ST_IDLE);
   assign accept     = note_valid && note_ready;
   assign silent     = note_on && (note_key == KEY_SILENT);

   assign cur_key  = slot_key[scan_idx_q];
   assign cur_gate = slot_gate[scan_idx_q];
   assign cur_age  = slot_age[scan_idx_q];

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && !silent) state_d = ST_SCAN;
         end
         ST_SCAN: begin
            if (scan_idx_q == IDX_LAST) state_d = ST_COMMIT;
         end
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // ---------------- event latch and scan records ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         ev_on_q       <= 1'b0;
         ev_key_q      <= KEY_SILENT;
         scan_idx_q    <= '0;
         match_found_q <= 1'b0;
         free_found_q  <= 1'b0;
         old_found_q   <= 1'b0;
         match_idx_q   <= '0;
         free_idx_q    <= '0;
         old_idx_q     <= '0;
         old_age_q     <= '0;
      end else if (state_q == ST_IDLE) begin
         if (accept && !silent) begin
            ev_on_q       <= note_on;
            ev_key_q      <= note_key;
            scan_idx_q    <= '0;
            match_found_q <= 1'b0;
            free_found_q  <= 1'b0;
            old_found_q   <= 1'b0;
            match_idx_q   <= '0;
            free_idx_q    <= '0;
            old_idx_q     <= '0;
            old_age_q     <= '0;
         end
      end else if (state_q == ST_SCAN) begin
         if (cur_gate && (cur_key == ev_key_q) && !match_found_q) begin
            match_found_q <= 1'b1;
            match_idx_q   <= scan_idx_q;
         end
         if (!cur_gate && !free_found_q) begin
            free_found_q <= 1'b1;
            free_idx_q   <= scan_idx_q;
         end
         // Strict compare keeps the lowest index on equal ages.
         if (cur_gate && (!old_found_q || (cur_age > old_age_q))) begin
            old_found_q <= 1'b1;
            old_idx_q   <= scan_idx_q;
            old_age_q   <= cur_age;
         end
         if (scan_idx_q != IDX_LAST) scan_idx_q <= scan_idx_q + 1'b1;
      end
   end

   // ---------------- commit decode ----------------
   always_comb begin
      load    = '0;
      retrig  = '0;
      rel     = '0;
      sel     = '0;
      age_inc = '0;
      steal_d = 1'b0;
      if (state_q == ST_COMMIT) begin
         if (ev_on_q) begin
            if (match_found_q) begin
               retrig[match_idx_q] = 1'b1;
               sel[match_idx_q]    = 1'b1;
            end else if (free_found_q) begin
               load[free_idx_q] = 1'b1;
               sel[free_idx_q]  = 1'b1;
            end else begin
               load[old_idx_q] = 1'b1;
               sel[old_idx_q]  = 1'b1;
               steal_d         = old_found_q;
            end
            // Everyone other than the touched voice gets older; the slot
            // itself ignores the request while ungated.
            age_inc = ~sel;
         end else if (match_found_q) begin
            rel[match_idx_q] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) steal <= 1'b0;
      else     steal <= steal_d;
   end

   // ---------------- voice pool ----------------
   for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
      voice_slot #(.AGE_WIDTH(AGE_WIDTH)) u_slot (
         .clk     (clk),
         .rst     (rst),
         .load    (load[i]),
         .retrig  (retrig[i]),
         .rel     (rel[i]),
         .age_inc (age_inc[i]),
         .key_in  (ev_key_q),
         .key     (slot_key[i]),
         .gate    (slot_gate[i]),
         .age     (slot_age[i])
      );
      assign voice_key[i*KEY_WIDTH +: KEY_WIDTH] = slot_key[i];
   end

   assign voice_gate = slot_gate;

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;
   import voice_allocator_pkg::*;

   localparam int NV = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            note_valid = 1'b0;
   logic            note_on = 1'b0;
   key_t            note_key = '0;
   logic            note_ready;
   logic [NV*7-1:0] voice_key;
   logic [NV-1:0]   voice_gate;
   logic            steal;

   voice_allocator #(.NUM_VOICES(NV), .AGE_WIDTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .note_valid (note_valid),
      .note_on    (note_on),
      .note_key   (note_key),
      .note_ready (note_ready),
      .voice_key  (voice_key),
      .voice_gate (voice_gate),
      .steal      (steal)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            id;
      logic [27:0]   keys;
      logic [3:0]    gate;
      logic          stl;
      int            acc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   mon_en = 0;

   function automatic logic [27:0] pk(input int k0, input int k1, input int k2, input int k3);
      return {7'(k3), 7'(k2), 7'(k1), 7'(k0)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic prev_ready = 1'b1;
      bit   chk_clear  = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (chk_clear) begin
            chk("steal_one_cycle", 32'(steal), 32'd0);
            chk_clear = 0;
         end
         if (mon_en && note_ready === 1'b1 && prev_ready === 1'b0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_commit", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("ev%0d_keys", e.id), 32'(voice_key), 32'(e.keys));
               chk($sformatf("ev%0d_gate", e.id), 32'(voice_gate), 32'(e.gate));
               chk($sformatf("ev%0d_steal", e.id), 32'(steal), 32'(e.stl));
               if (e.acc >= 0)
                  chk($sformatf("ev%0d_latency", e.id), 32'(cyc - e.acc), 32'd5);
               chk_clear = 1;
            end
         end
         prev_ready = note_ready;
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_ready();
      int n = 0;
      while (note_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (note_ready !== 1'b1) chk("ready_timeout", 32'(note_ready), 32'd1);
   endtask

   task automatic send(input int id, input bit on, input int key, input bit has_exp,
                       input logic [27:0] ek, input logic [3:0] eg, input bit es);
      exp_t e;
      wait_ready();
      @(negedge clk);
      note_valid = 1'b1;
      note_on    = on;
      note_key   = 7'(key);
      @(posedge clk);
      #1;
      note_valid = 1'b0;
      if (has_exp) begin
         e.id = id; e.keys = ek; e.gate = eg; e.stl = es; e.acc = cyc;
         exp_q.push_back(e);
         @(negedge clk);
         chk($sformatf("ev%0d_ready_low", id), 32'(note_ready), 32'd0);
      end else begin
         @(negedge clk);
         chk($sformatf("ev%0d_silent_ready", id), 32'(note_ready), 32'd1);
      end
   endtask

   initial begin
      exp_t e;
      int   n;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(note_ready), 32'd1);
      chk("rst_keys", 32'(voice_key), 32'd0);
      chk("rst_gate", 32'(voice_gate), 32'd0);
      chk("rst_steal", 32'(steal), 32'd0);
      mon_en = 1;

      // Fill the pool; ages after #4: 3,2,1,0
      send(1, 1, 49, 1, pk(49, 0, 0, 0),    4'b0001, 0);
      send(2, 1, 52, 1, pk(49, 52, 0, 0),   4'b0011, 0);
      send(3, 1, 56, 1, pk(49, 52, 56, 0),  4'b0111, 0);
      send(4, 1, 61, 1, pk(49, 52, 56, 61), 4'b1111, 0);
      // Steal oldest v0; ages 0,3,2,1
      send(5, 1, 64, 1, pk(64, 52, 56, 61), 4'b1111, 1);
      // Retrigger 52 twice; ages 1,0,3,2 then 2,0,4,3
      send(6, 1, 52, 1, pk(64, 52, 56, 61), 4'b1111, 0);
      send(7, 1, 52, 1, pk(64, 52, 56, 61), 4'b1111, 0);
      // Steal now picks v2 (age 4), not the retriggered v1; ages 3,1,0,4
      send(8, 1, 72, 1, pk(64, 52, 72, 61), 4'b1111, 1);
      // Release 61: gate drops, key kept
      send(9, 0, 61, 1, pk(64, 52, 72, 61), 4'b0111, 0);
      // New note lands in the released voice without stealing
      send(10, 1, 70, 1, pk(64, 52, 72, 70), 4'b1111, 0);
      // Note-off for an absent key changes nothing
      send(11, 0, 30, 1, pk(64, 52, 72, 70), 4'b1111, 0);
      // Silent note-on is swallowed in IDLE
      send(12, 1, 0, 0, '0, '0, 0);
      send(13, 0, 64, 1, pk(64, 52, 72, 70), 4'b1110, 0);
      // Ungated voice with same key is a free slot, not a match
      send(14, 1, 64, 1, pk(64, 52, 72, 70), 4'b1111, 0);

      // Reset in the middle of a scan: event dropped, everything cleared
      wait_ready();
      @(negedge clk);
      note_valid = 1'b1; note_on = 1'b1; note_key = 7'd40;
      @(posedge clk);
      #1 note_valid = 1'b0;
      e.id = 15; e.keys = '0; e.gate = '0; e.stl = 0; e.acc = -1;
      exp_q.push_back(e);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("ev15_ready_after_rst", 32'(note_ready), 32'd1);

      send(16, 1, 40, 1, pk(40, 0, 0, 0), 4'b0001, 0);

      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
